// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package mdu_pkg;

    // Operation encodings on the op input; 6 and 7 are no-ops.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    // Down-counter width: enough to hold the larger latency minus one, never zero bits.
    function automatic int cnt_width(input int mult_lat, input int div_lat);
        int m;
        int w;
        m = (mult_lat > div_lat) ? mult_lat : div_lat;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with fixed multi-cycle latency and architectural HI/LO.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no op in flight; accepts mult/div/mthi/mtlo on start
//  BUSY  | result pending; counter counts down, commit when it hits 0
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HiData,
    output logic [31:0] LoData
);

    localparam int CNT_W = cnt_width(MULT_LAT, DIV_LAT);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvsr;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Result datapath: products from sign/zero-extended operands; one unsigned
    // divider on magnitudes serves both DIV and DIVU, signs fixed up afterwards.
    // The most-negative / -1 case falls out as 0x80000000 with remainder 0.
    always_comb begin
        prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u     = {32'd0, A} * {32'd0, B};
        div_signed = (op == MD_DIV);
        a_mag      = (div_signed && A[31]) ? (32'd0 - A) : A;
        b_mag      = (div_signed && B[31]) ? (32'd0 - B) : B;
        dvsr       = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / dvsr;
        r_mag      = a_mag % dvsr;
        quot       = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
        rem        = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT: begin
                            state_d   = BUSY;
                            cnt_d     = MULT_LOAD;
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                        end
                        MD_MULTU: begin
                            state_d   = BUSY;
                            cnt_d     = MULT_LOAD;
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d   = BUSY;
                            cnt_d     = DIV_LOAD;
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            // Divide by zero still takes the full latency but leaves HI/LO alone.
                            pend_wr_d = (B != 32'd0);
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any op in flight without committing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign HiData = hi_q;
    assign LoData = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO and busy
// length per accepted mult/div; a monitor checks them when busy falls.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HiData;
    logic [31:0] LoData;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HiData (HiData),
        .LoData (LoData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Monitor: on every busy falling edge pop one expectation and compare.
    int   busy_cnt = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit got=busy_fall exp=none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_hi"}, HiData, e.hi);
                    check({e.name, "_lo"}, LoData, e.lo);
                    check({e.name, "_lat"}, 32'(busy_cnt), 32'(e.lat));
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
        end
    end

    // Present one op for one cycle, then scramble operands to prove they are not re-sampled.
    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd7;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic wr);
        exp_t e;
        if (wr) begin
            m_hi = eh;
            m_lo = el;
        end
        e.hi   = m_hi;
        e.lo   = m_lo;
        e.lat  = (o == MD_MULT || o == MD_MULTU) ? ML : DL;
        e.name = name;
        sb.push_back(e);
        drive(o, a, b);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=busy exp=idle", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HiData, 32'd0);
        check("rst_lo", LoData, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
        wait_idle("mult_neg");
        issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        wait_idle("multu");
        issue("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        wait_idle("div_neg");
        issue("divu_by0", MD_DIVU, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0);
        wait_idle("divu_by0");

        // MTHI and DIVU issued while the MULT is in flight are both dropped.
        issue("mult_ign", MD_MULT, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 1'b1);
        drive(MD_MTHI, 32'h55, 32'd0);
        drive(MD_DIVU, 32'd100, 32'd3);
        wait_idle("mult_ign");
        @(negedge clk);
        check("ign_busy", 32'(busy), 32'd0);

        // MTLO in IDLE: one-cycle write, HI untouched, no busy.
        drive(MD_MTLO, 32'h1234, 32'd0);
        check("mtlo_lo", LoData, 32'h1234);
        check("mtlo_hi", HiData, 32'd0);
        m_lo = 32'h1234;
        begin
            bit rose;
            rose = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (busy) rose = 1'b1;
            end
            check("mtlo_busy", 32'(rose), 32'd0);
        end

        drive(MD_MTHI, 32'hDEAD, 32'd0);
        check("mthi_hi", HiData, 32'hDEAD);
        check("mthi_lo", LoData, 32'h1234);
        m_hi = 32'hDEAD;

        // op 7 with start does nothing.
        drive(3'd7, 32'hAAAA_AAAA, 32'h1);
        @(negedge clk);
        check("nop_hi", HiData, 32'hDEAD);
        check("nop_lo", LoData, 32'h1234);
        check("nop_busy", 32'(busy), 32'd0);

        // Back-to-back ops: each issued the first cycle busy is low.
        issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
        wait_idle("div_ovf");
        issue("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b1);
        wait_idle("div_negb");
        issue("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        wait_idle("divu");
        issue("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b1);
        wait_idle("mult_min");
        issue("div_by0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 1'b0);
        wait_idle("div_by0");

        // Reset mid-op aborts without committing.
        drive(MD_MULTU, 32'd3, 32'd5);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_hi", HiData, 32'd0);
        check("rstmid_lo", LoData, 32'd0);
        repeat (8) @(negedge clk);
        check("rstmid_hi_late", HiData, 32'd0);
        check("rstmid_lo_late", LoData, 32'd0);
        check("rstmid_busy_late", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
